// File: rtl/audio_fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_fft_pkg
// Description : Shared constants for the audio FFT chain. Holds the FFT
//               geometry, sample widths, the peak-detector state encoding and
//               the bin-to-frequency scale used by game logic.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_fft_pkg;

  localparam int LEN   = 1024;  // FFT length in points
  localparam int LBITS = 10;    // log2(LEN), bin address width
  localparam int BITS  = 16;    // power sample width
  localparam int EBITS = 6;     // block-floating exponent width

  // Frequency spacing of one bin in Q8 Hz (audio rate / LEN).
  localparam int AUDIO_RATE_HZ = 48000;
  localparam int BIN_HZ_Q8     = (AUDIO_RATE_HZ * 256) / LEN;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    SCAN      = 3'd3,
    DRAIN     = 3'd4,
    REPORT    = 3'd5
  } fft_state_e;

  // Plain-vector encodings of the same states for the controller register.
  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_START     = START;
  localparam logic [2:0] ST_WAIT_DONE = WAIT_DONE;
  localparam logic [2:0] ST_SCAN      = SCAN;
  localparam logic [2:0] ST_DRAIN     = DRAIN;
  localparam logic [2:0] ST_REPORT    = REPORT;

endpackage
`default_nettype wire

// File: rtl/fft_peak_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_peak_detector_if
// Description : Bundle between the peak detector, the FFT controller read-out
//               port and the game-logic result consumer.
//   master : the peak detector (drives start pulse, read address, results)
//   slave  : the environment (run/threshold, FFT done, power, exponent)
//   Signals: iRun, iThreshold, oFftStart, iFftDone, oReadAddr, iPower, iExp,
//            oPeakBin, oPeakPower, oExp, oEnergy, oSilent, oValid, oTimeout
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_peak_detector_if
  import audio_fft_pkg::*;
#(
  parameter int LBITS = audio_fft_pkg::LBITS,
  parameter int BITS  = audio_fft_pkg::BITS,
  parameter int EBITS = audio_fft_pkg::EBITS
);
  logic                  iRun;
  logic [BITS-1:0]       iThreshold;
  logic                  oFftStart;
  logic                  iFftDone;
  logic [LBITS-1:0]      oReadAddr;
  logic [BITS-1:0]       iPower;
  logic [EBITS-1:0]      iExp;
  logic [LBITS-1:0]      oPeakBin;
  logic [BITS-1:0]       oPeakPower;
  logic [EBITS-1:0]      oExp;
  logic [BITS+LBITS-1:0] oEnergy;
  logic                  oSilent;
  logic                  oValid;
  logic                  oTimeout;

  modport master (
    input  iRun, iThreshold, iFftDone, iPower, iExp,
    output oFftStart, oReadAddr, oPeakBin, oPeakPower, oExp, oEnergy,
           oSilent, oValid, oTimeout
  );

  modport slave (
    output iRun, iThreshold, iFftDone, iPower, iExp,
    input  oFftStart, oReadAddr, oPeakBin, oPeakPower, oExp, oEnergy,
           oSilent, oValid, oTimeout
  );

endinterface
`default_nettype wire

// File: rtl/fft_peak_detector_peak_accum.sv
`default_nettype none
// ============================================================================
// Module      : peak_accum
// Description : Read-latency alignment plus max/argmax search and saturating
//               energy sum over one scan of power samples.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : start of frame; zero the search and energy
//   i_valid     : an address is being issued to the RAM this cycle
//   i_addr      : the address being issued
//   i_power     : RAM data, RD_LAT cycles after the matching address
//   o_max_power : largest power seen since clear
//   o_max_bin   : lowest bin holding o_max_power
//   o_energy    : saturating sum of all consumed powers
// Revision    : 1.0 - initial release
// ============================================================================
module peak_accum
  import audio_fft_pkg::*;
#(
  parameter int LBITS   = audio_fft_pkg::LBITS,
  parameter int BITS    = audio_fft_pkg::BITS,
  parameter int RD_LAT  = 2,
  parameter int MIN_BIN = 2
) (
  input  wire                    clk,
  input  wire                    rst_n,
  input  wire                    i_clear,
  input  wire                    i_valid,
  input  wire  [LBITS-1:0]       i_addr,
  input  wire  [BITS-1:0]        i_power,
  output logic [BITS-1:0]        o_max_power,
  output logic [LBITS-1:0]       o_max_bin,
  output logic [BITS+LBITS-1:0]  o_energy
);

  localparam int EW = BITS + LBITS;

  logic [RD_LAT-1:0] r_vld_pipe;
  logic [LBITS-1:0]  r_addr_pipe [RD_LAT];
  logic [BITS-1:0]   r_max_power;
  logic [LBITS-1:0]  r_max_bin;
  logic [EW-1:0]     r_energy;

  logic              w_hit;
  logic [EW:0]       w_sum;

  // The tail of the delay line lines up with the RAM output.
  assign w_hit = r_vld_pipe[RD_LAT-1];
  // One spare bit catches the carry that signals saturation.
  assign w_sum = (EW+1)'(r_energy) + (EW+1)'(i_power);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe  <= '0;
      for (int i = 0; i < RD_LAT; i++) r_addr_pipe[i] <= '0;
      r_max_power <= '0;
      r_max_bin   <= '0;
      r_energy    <= '0;
    end else if (i_clear) begin
      // An all-zero frame reports the first scanned bin.
      r_vld_pipe  <= '0;
      r_max_power <= '0;
      r_max_bin   <= LBITS'(MIN_BIN);
      r_energy    <= '0;
    end else begin
      r_vld_pipe[0]  <= i_valid;
      r_addr_pipe[0] <= i_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_addr_pipe[i] <= r_addr_pipe[i-1];
      end
      if (w_hit) begin
        // Strict compare with an ascending scan keeps the lowest tied bin.
        if (i_power > r_max_power) begin
          r_max_power <= i_power;
          r_max_bin   <= r_addr_pipe[RD_LAT-1];
        end
        r_energy <= w_sum[EW] ? '1 : w_sum[EW-1:0];
      end
    end
  end

  assign o_max_power = r_max_power;
  assign o_max_bin   = r_max_bin;
  assign o_energy    = r_energy;

endmodule
`default_nettype wire

// File: rtl/fft_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : fft_peak_detector
// Description : Starts each FFT frame, waits for completion, scans the lower
//               half of the power spectrum and reports the dominant bin, its
//               power, the frame exponent and total energy as a pulsed event.
//   iCLK   : system clock shared with the FFT controller
//   iRST_N : asynchronous active-low reset
//   bus    : fft_peak_detector_if.master (run/threshold in, FFT start/done
//            handshake, result RAM read port, registered result outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_detector
  import audio_fft_pkg::*;
#(
  parameter int LEN     = audio_fft_pkg::LEN,
  parameter int LBITS   = audio_fft_pkg::LBITS,
  parameter int BITS    = audio_fft_pkg::BITS,
  parameter int EBITS   = audio_fft_pkg::EBITS,
  parameter int MIN_BIN = 2,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 1 << 20
) (
  input  wire                 iCLK,
  input  wire                 iRST_N,
  fft_peak_detector_if.master bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int DW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  localparam logic [LBITS-1:0] C_FIRST_BIN  = LBITS'(MIN_BIN);
  localparam logic [LBITS-1:0] C_LAST_BIN   = LBITS'(LEN/2 - 1);
  localparam logic [TW-1:0]    C_TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0]    C_DRAIN_LAST = DW'(RD_LAT - 1);

  logic [2:0]            r_state;
  logic                  r_done_d;
  logic [TW-1:0]         r_to_cnt;
  logic [DW-1:0]         r_drain_cnt;
  logic [LBITS-1:0]      r_addr;
  logic [EBITS-1:0]      r_exp_cap;

  logic [LBITS-1:0]      r_peak_bin;
  logic [BITS-1:0]       r_peak_power;
  logic [EBITS-1:0]      r_exp;
  logic [BITS+LBITS-1:0] r_energy;
  logic                  r_silent;
  logic                  r_valid;
  logic                  r_timeout;

  logic                  w_done_rise;
  logic                  w_issue;
  logic                  w_clear;
  logic [BITS-1:0]       w_max_power;
  logic [LBITS-1:0]      w_max_bin;
  logic [BITS+LBITS-1:0] w_energy;

  // r_done_d tracks the level every cycle, so on the first WAIT_DONE cycle it
  // holds the level seen in START: a done level already high at entry never
  // reads as a rising edge.
  assign w_done_rise = bus.iFftDone & ~r_done_d;
  assign w_issue     = (r_state == ST_SCAN);
  assign w_clear     = (r_state == ST_WAIT_DONE) && w_done_rise;

  peak_accum #(
    .LBITS   (LBITS),
    .BITS    (BITS),
    .RD_LAT  (RD_LAT),
    .MIN_BIN (MIN_BIN)
  ) u_peak_accum (
    .clk         (iCLK),
    .rst_n       (iRST_N),
    .i_clear     (w_clear),
    .i_valid     (w_issue),
    .i_addr      (r_addr),
    .i_power     (bus.iPower),
    .o_max_power (w_max_power),
    .o_max_bin   (w_max_bin),
    .o_energy    (w_energy)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state      <= ST_IDLE;
      r_done_d     <= 1'b0;
      r_to_cnt     <= '0;
      r_drain_cnt  <= '0;
      r_addr       <= '0;
      r_exp_cap    <= '0;
      r_peak_bin   <= '0;
      r_peak_power <= '0;
      r_exp        <= '0;
      r_energy     <= '0;
      r_silent     <= 1'b0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_done_d <= bus.iFftDone;
      r_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.iRun) r_state <= ST_START;
        end
        ST_START: begin
          r_to_cnt <= '0;
          r_state  <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // A done edge on the final wait cycle still wins over the timeout.
          if (w_done_rise) begin
            r_exp_cap <= bus.iExp;
            r_addr    <= C_FIRST_BIN;
            r_state   <= ST_SCAN;
          end else if (r_to_cnt == C_TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_SCAN: begin
          // Only the lower half is read; the address parks on the last bin.
          if (r_addr == C_LAST_BIN) begin
            r_drain_cnt <= '0;
            r_state     <= ST_DRAIN;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == C_DRAIN_LAST) r_state <= ST_REPORT;
          else                             r_drain_cnt <= r_drain_cnt + 1'b1;
        end
        ST_REPORT: begin
          r_peak_bin   <= w_max_bin;
          r_peak_power <= w_max_power;
          r_exp        <= r_exp_cap;
          r_energy     <= w_energy;
          r_silent     <= (w_max_power < bus.iThreshold);
          r_valid      <= 1'b1;
          r_timeout    <= 1'b0;
          r_state      <= bus.iRun ? ST_START : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.oFftStart  = (r_state == ST_START);
  assign bus.oReadAddr  = r_addr;
  assign bus.oPeakBin   = r_peak_bin;
  assign bus.oPeakPower = r_peak_power;
  assign bus.oExp       = r_exp;
  assign bus.oEnergy    = r_energy;
  assign bus.oSilent    = r_silent;
  assign bus.oValid     = r_valid;
  assign bus.oTimeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_peak_detector
// Description : Directed bench for fft_peak_detector with a two-stage RAM
//               model, plus a narrow peak_accum instance for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_peak_detector;
  import audio_fft_pkg::*;

  localparam int DONE_DLY = 40;  // cycles from start pulse to done edge
  localparam int LATENCY  = (1024/2 - 2) + 2 + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  fft_peak_detector_if #(.LBITS(10), .BITS(16), .EBITS(6)) bus ();

  fft_peak_detector #(
    .LEN(1024), .LBITS(10), .BITS(16), .EBITS(6),
    .MIN_BIN(2), .RD_LAT(2), .TIMEOUT(64)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  // Result RAM: registered address then registered output.
  logic [15:0] mem [1024];
  logic [15:0] ram_q1;
  always_ff @(posedge clk) begin
    ram_q1     <= mem[bus.oReadAddr];
    bus.iPower <= ram_q1;
  end

  bit upper_read = 1'b0;
  always @(negedge clk) if (bus.oReadAddr > 10'd511) upper_read = 1'b1;

  // Narrow accumulator: 17-bit energy to exercise saturation.
  logic        sa_clear, sa_valid;
  logic [0:0]  sa_addr;
  logic [15:0] sa_power;
  logic [15:0] sa_max;
  logic [0:0]  sa_bin;
  logic [16:0] sa_energy;
  peak_accum #(.LBITS(1), .BITS(16), .RD_LAT(1), .MIN_BIN(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_clear(sa_clear), .i_valid(sa_valid),
    .i_addr(sa_addr), .i_power(sa_power), .o_max_power(sa_max),
    .o_max_bin(sa_bin), .o_energy(sa_energy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 1024; i++) mem[i] = v;
  endtask

  // Waits for the start pulse, raises done DONE_DLY cycles later and counts
  // cycles from that edge to oValid. drop_at>0 drops iRun at that count.
  task automatic run_frame(input int drop_at, output int lat, output bit got);
    int c;
    got = 1'b0;
    lat = 0;
    c   = 0;
    while (!bus.oFftStart && c < 200) begin @(negedge clk); c++; end
    if (!bus.oFftStart) return;
    bus.iFftDone = 1'b0;
    repeat (DONE_DLY) @(negedge clk);
    bus.iFftDone = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == drop_at) bus.iRun = 1'b0;
      if (bus.oValid) begin got = 1'b1; lat = k; break; end
    end
  endtask

  task automatic pulse_run();
    bus.iRun = 1'b1;
    @(negedge clk);
    bus.iRun = 1'b0;
  endtask

  initial begin
    int  lat, c;
    bit  got, seen;

    rst_n = 1'b0;
    bus.iRun = 1'b0; bus.iThreshold = '0; bus.iFftDone = 1'b0; bus.iExp = '0;
    sa_clear = 1'b0; sa_valid = 1'b0; sa_addr = '0; sa_power = '0;
    fill(16'h0000);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_start",  {31'd0, bus.oFftStart}, 32'd0);
    check("rst_valid",  {31'd0, bus.oValid},    32'd0);
    check("rst_addr",   32'(bus.oReadAddr),     32'd0);
    check("rst_bin",    32'(bus.oPeakBin),      32'd0);
    check("rst_energy", 32'(bus.oEnergy),       32'd0);
    check("rst_tmo",    {31'd0, bus.oTimeout},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Saturation on the 17-bit accumulator
    sa_clear = 1'b1; @(negedge clk); sa_clear = 1'b0;
    sa_power = 16'hFFFF; sa_valid = 1'b1; sa_addr = 1'b0; @(negedge clk);
    sa_addr = 1'b1; @(negedge clk);
    sa_valid = 1'b0; repeat (3) @(negedge clk);
    check("sat_two",  32'(sa_energy), 32'h1FFFE);
    check("sat_max",  32'(sa_max),    32'hFFFF);
    check("sat_bin",  32'(sa_bin),    32'd0);
    sa_valid = 1'b1; @(negedge clk); sa_valid = 1'b0; repeat (3) @(negedge clk);
    check("sat_clip", 32'(sa_energy), 32'h1FFFF);
    sa_valid = 1'b1; @(negedge clk); sa_valid = 1'b0; repeat (3) @(negedge clk);
    check("sat_hold", 32'(sa_energy), 32'h1FFFF);

    // Single tone at bin 37
    fill(16'h0000); mem[37] = 16'h4000;
    bus.iThreshold = 16'h0100; bus.iExp = 6'h2A;
    pulse_run();
    run_frame(0, lat, got);
    check("f1_got",    {31'd0, got},           32'd1);
    check("f1_lat",    32'(lat),               32'(LATENCY));
    check("f1_bin",    32'(bus.oPeakBin),      32'd37);
    check("f1_pow",    32'(bus.oPeakPower),    32'h4000);
    check("f1_energy", 32'(bus.oEnergy),       32'h4000);
    check("f1_silent", {31'd0, bus.oSilent},   32'd0);
    check("f1_exp",    32'(bus.oExp),          32'h2A);
    check("f1_nostart",{31'd0, bus.oFftStart}, 32'd0);
    @(negedge clk);
    check("f1_pulse",  {31'd0, bus.oValid},    32'd0);

    // All-zero spectrum, zero threshold
    fill(16'h0000); bus.iThreshold = 16'h0000; bus.iExp = 6'h01;
    pulse_run();
    run_frame(0, lat, got);
    check("z_got",    {31'd0, got},         32'd1);
    check("z_bin",    32'(bus.oPeakBin),    32'd2);
    check("z_pow",    32'(bus.oPeakPower),  32'd0);
    check("z_silent", {31'd0, bus.oSilent}, 32'd0);

    // Tie between 50 and 200; bin 1 and upper-half bin 600 are excluded
    fill(16'h0000);
    mem[1] = 16'hFFFF; mem[50] = 16'h7FFF; mem[200] = 16'h7FFF; mem[600] = 16'hFFFF;
    bus.iThreshold = 16'h8000; bus.iExp = 6'h05;
    pulse_run();
    run_frame(0, lat, got);
    check("t_got",    {31'd0, got},         32'd1);
    check("t_bin",    32'(bus.oPeakBin),    32'd50);
    check("t_pow",    32'(bus.oPeakPower),  32'h7FFF);
    check("t_energy", 32'(bus.oEnergy),     32'hFFFE);
    check("t_silent", {31'd0, bus.oSilent}, 32'd1);
    check("t_exp",    32'(bus.oExp),        32'h05);

    // Every bin full scale: 510 * 0xFFFF
    fill(16'hFFFF); bus.iThreshold = 16'hFFFF;
    pulse_run();
    run_frame(0, lat, got);
    check("full_got",    {31'd0, got},         32'd1);
    check("full_bin",    32'(bus.oPeakBin),    32'd2);
    check("full_energy", 32'(bus.oEnergy),     32'h1FDFE02);
    check("full_silent", {31'd0, bus.oSilent}, 32'd0);

    // Done held high from before START: no edge, so time out
    fill(16'h0000); mem[37] = 16'h4000; bus.iThreshold = 16'h0100;
    bus.iFftDone = 1'b1;
    pulse_run();
    check("to_start", {31'd0, bus.oFftStart}, 32'd1);
    c = 0; seen = 1'b0;
    while (!bus.oTimeout && c < 200) begin
      @(negedge clk); c++;
      if (bus.oValid) seen = 1'b1;
    end
    // 64 cycles in WAIT_DONE, flag registered on the edge ending the last.
    check("to_cycle", 32'(c),            32'd65);
    check("to_valid", {31'd0, seen},     32'd0);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.oFftStart) seen = 1'b1; end
    check("to_idle",   {31'd0, seen},         32'd0);
    check("to_sticky", {31'd0, bus.oTimeout}, 32'd1);

    // Next good frame clears the sticky timeout
    pulse_run();
    run_frame(0, lat, got);
    check("rec_got", {31'd0, got},          32'd1);
    check("rec_tmo", {31'd0, bus.oTimeout}, 32'd0);
    check("rec_bin", 32'(bus.oPeakBin),     32'd37);

    // iRun held: back-to-back frames, then drop iRun mid-scan
    bus.iRun = 1'b1;
    @(negedge clk);
    run_frame(0, lat, got);
    check("run_got",   {31'd0, got},           32'd1);
    check("run_next",  {31'd0, bus.oFftStart}, 32'd1);
    run_frame(100, lat, got);
    check("drop_got",  {31'd0, got},           32'd1);
    check("drop_lat",  32'(lat),               32'(LATENCY));
    check("drop_bin",  32'(bus.oPeakBin),      32'd37);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (bus.oFftStart) seen = 1'b1; end
    check("drop_stop", {31'd0, seen},          32'd0);

    // Asynchronous reset in the middle of a scan
    bus.iRun = 1'b1;
    c = 0;
    while (!bus.oFftStart && c < 200) begin @(negedge clk); c++; end
    bus.iFftDone = 1'b0;
    repeat (DONE_DLY) @(negedge clk);
    bus.iFftDone = 1'b1;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_addr",   32'(bus.oReadAddr),     32'd0);
    check("ar_bin",    32'(bus.oPeakBin),      32'd0);
    check("ar_pow",    32'(bus.oPeakPower),    32'd0);
    check("ar_energy", 32'(bus.oEnergy),       32'd0);
    check("ar_start",  {31'd0, bus.oFftStart}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    while (!bus.oFftStart && c < 10) begin @(negedge clk); c++; end
    check("ar_restart", {31'd0, (bus.oFftStart && c <= 2)}, 32'd1);
    bus.iRun = 1'b0;
    run_frame(0, lat, got);
    check("ar_got", {31'd0, got},      32'd1);
    check("ar_res", 32'(bus.oPeakBin), 32'd37);

    check("upper_half", {31'd0, upper_read}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
